bus_arbiter: RTL and testbench

Two-master arbiter for the system bus. Grants exclusive bus ownership to master 1 or master 2 (the command-processor read/write masters), enforces a one-cycle dead turnaround between owners, and reclaims the bus from a master that holds it longer than a programmable limit. Sits between the masters' request/release handshakes and the bus address/data mux select.

---
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master system bus arbiter with one-cycle dead turnaround
// between owners and a programmable hold limit that reclaims the bus.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined     -> on a tie, grant the master that did not own the bus last
//   not defined -> fixed priority, master 1 wins every tie
module bus_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_m1,
    input  logic       req_m2,
    input  logic       done_m1,
    input  logic       done_m2,
    output logic       gnt_m1,
    output logic       gnt_m2,
    output logic [1:0] bus_owner,
    output logic       bus_busy,
    output logic       timeout_m1,
    output logic       timeout_m2
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M1 = 2'd1,
        GRANT_M2 = 2'd2,
        HANDOVER = 2'd3
    } state_t;

    // last_owner encoding: 0 = m1, 1 = m2
    localparam logic LAST_M1 = 1'b0;
    localparam logic LAST_M2 = 1'b1;

    // Release is forced in the last permitted hold cycle, so the counter
    // never has to saturate.
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             gnt_m1_q, gnt_m2_q, busy_q, to_m1_q, to_m2_q;
    logic [1:0]       owner_q;
    logic             to_m1_d, to_m2_d;

    // Arbitration used from both IDLE and HANDOVER.
    function automatic state_t arbitrate(input logic r1, input logic r2,
                                         input logic last);
        state_t s;
        s = IDLE;
        if (r1 && r2) begin
`ifdef ARB_ROUND_ROBIN_EN
            s = (last == LAST_M1) ? GRANT_M2 : GRANT_M1;
`else
            s = GRANT_M1;
`endif
        end else if (r1) begin
            s = GRANT_M1;
        end else if (r2) begin
            s = GRANT_M2;
        end
        return s;
    endfunction

`ifndef ARB_ROUND_ROBIN_EN
    // last_owner is still tracked in fixed-priority builds but not consulted.
    logic unused_last_q;
    assign unused_last_q = last_q;
`endif

    // Next-state: release on done/request drop, forced release at hold limit.
    // A done in the limit cycle is a normal release and suppresses the pulse.
    always_comb begin
        state_d = state_q;
        to_m1_d = 1'b0;
        to_m2_d = 1'b0;
        case (state_q)
            IDLE, HANDOVER: state_d = arbitrate(req_m1, req_m2, last_q);
            GRANT_M1: begin
                if (done_m1 || !req_m1) begin
                    state_d = HANDOVER;
                end else if (cnt_q == CNT_LIM) begin
                    state_d = HANDOVER;
                    to_m1_d = 1'b1;
                end
            end
            GRANT_M2: begin
                if (done_m2 || !req_m2) begin
                    state_d = HANDOVER;
                end else if (cnt_q == CNT_LIM) begin
                    state_d = HANDOVER;
                    to_m2_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, hold counter, last owner and registered output decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= LAST_M2;
            gnt_m1_q <= 1'b0;
            gnt_m2_q <= 1'b0;
            owner_q  <= 2'b00;
            busy_q   <= 1'b0;
            to_m1_q  <= 1'b0;
            to_m2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_d == GRANT_M1 || state_d == GRANT_M2) &&
                (state_q == IDLE || state_q == HANDOVER)) begin
                cnt_q <= '0;
            end else if (state_q == GRANT_M1 || state_q == GRANT_M2) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_d == GRANT_M1 && state_q != GRANT_M1) last_q <= LAST_M1;
            if (state_d == GRANT_M2 && state_q != GRANT_M2) last_q <= LAST_M2;
            gnt_m1_q <= (state_d == GRANT_M1);
            gnt_m2_q <= (state_d == GRANT_M2);
            owner_q  <= {state_d == GRANT_M2, state_d == GRANT_M1};
            busy_q   <= (state_d == GRANT_M1) || (state_d == GRANT_M2);
            to_m1_q  <= to_m1_d;
            to_m2_q  <= to_m2_d;
        end
    end

    assign gnt_m1     = gnt_m1_q;
    assign gnt_m2     = gnt_m2_q;
    assign bus_owner  = owner_q;
    assign bus_busy   = busy_q;
    assign timeout_m1 = to_m1_q;
    assign timeout_m2 = to_m2_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (TIMEOUT=8). The driver applies one
// directed vector per cycle and queues the outputs expected after the next
// rising edge; the monitor pops and compares once per cycle.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_m1 = 1'b0, req_m2 = 1'b0, done_m1 = 1'b0, done_m2 = 1'b0;
    logic       gnt_m1, gnt_m2, bus_busy, timeout_m1, timeout_m2;
    logic [1:0] bus_owner;

    int checks = 0;
    int passes = 0;
    logic [6:0] exp_q[$];
    string      name_q[$];
    string      tag = "";

    bus_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_m1(req_m1), .req_m2(req_m2),
        .done_m1(done_m1), .done_m2(done_m2),
        .gnt_m1(gnt_m1), .gnt_m2(gnt_m2),
        .bus_owner(bus_owner), .bus_busy(bus_busy),
        .timeout_m1(timeout_m1), .timeout_m2(timeout_m2)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs; expected outputs after the following edge.
    task automatic step(input logic rst, input logic r1, input logic r2,
                        input logic d1, input logic d2,
                        input logic g1, input logic g2,
                        input logic t1, input logic t2);
        @(negedge clk);
        reset = rst; req_m1 = r1; req_m2 = r2; done_m1 = d1; done_m2 = d2;
        exp_q.push_back({g1, g2, g2, g1, g1 | g2, t1, t2});
        name_q.push_back(tag);
    endtask

    // Monitor: outputs {gnt_m1,gnt_m2,bus_owner,bus_busy,timeout_m1,timeout_m2}
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [6:0] e, a;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {gnt_m1, gnt_m2, bus_owner, bus_busy, timeout_m1, timeout_m2};
                checks++;
                if (a === e) passes++;
                else $display("FAIL %s: got %b expected %b (g1 g2 own busy to1 to2) at %0t",
                              n, a, e, $time);
            end
        end
    end

    initial begin
        int own;
        repeat (2) @(posedge clk);

        // Reset held with req_m1 asserted, then grant one cycle after release
        tag = "reset_hold";
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tag = "reset_release_grant";
        step(1, 1, 0, 0, 0, 1, 0, 0, 0);
        tag = "m1_done_release";
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single m2 transaction: done 5 cycles after grant -> 6 grant cycles;
        // a spurious done_m1 while m2 owns must be ignored
        tag = "m2_single";
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        tag = "m2_done_handover";
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tag = "m2_idle";
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Timeout: m1 held 8 cycles with m2 pending, then m2 granted
        tag = "to_grant";
        step(1, 1, 0, 0, 0, 1, 0, 0, 0);
        tag = "to_hold";
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0, 1, 0, 0, 0);
        tag = "to_pulse";
        step(1, 1, 1, 0, 0, 0, 0, 1, 0);
        tag = "to_next_owner";
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        // Request drop mid-grant: handover, no timeout pulse
        tag = "req_drop";
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Tie from IDLE, each owner releases on its third grant cycle
        tag = "tie";
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            own = (k % 2 == 0) ? 1 : 2;
`else
            own = 1;
`endif
            step(1, 1, 1, 0, 0, own == 1, own == 2, 0, 0);
            step(1, 1, 1, 0, 0, own == 1, own == 2, 0, 0);
            step(1, 1, 1, 0, 0, own == 1, own == 2, 0, 0);
            step(1, 1, 1, own == 1, own == 2, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-grant: m2 at counter 5, reset drops grant, no pulse
        tag = "rst_mid_grant";
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tag = "rst_tie_m1";
        step(1, 1, 1, 0, 0, 1, 0, 0, 0);
        // Counter restarted at grant: full 8-cycle hold before forced release
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, 1, 0, 0, 0);
        tag = "rst_to_pulse";
        step(1, 1, 0, 0, 0, 0, 0, 1, 0);
        tag = "rst_end";
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
